// File: rtl/alu_issue_arbiter_if.sv
// Bundle of requester, ALU-facing and response signals for alu_issue_arbiter.
// The master side is the environment; the slave side is the arbiter.
interface alu_issue_arbiter_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    logic          REQ0_VALID, REQ0_READY, REQ0_CIN, REQ0_MODE;
    logic [DW-1:0] REQ0_OPA, REQ0_OPB;
    logic [CW-1:0] REQ0_CMD;
    logic          REQ1_VALID, REQ1_READY, REQ1_CIN, REQ1_MODE;
    logic [DW-1:0] REQ1_OPA, REQ1_OPB;
    logic [CW-1:0] REQ1_CMD;

    logic          ALU_CE, ALU_CIN, ALU_MODE;
    logic [1:0]    ALU_INP_VALID;
    logic [DW-1:0] ALU_OPA, ALU_OPB;
    logic [CW-1:0] ALU_CMD;
    logic [DW+1:0] ALU_RES;
    logic          ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR;

    logic          RSP_VALID, RSP_READY, RSP_ID;
    logic [DW+1:0] RSP_RES;
    logic [5:0]    RSP_FLAGS;

    modport master (
        output REQ0_VALID, REQ0_OPA, REQ0_OPB, REQ0_CIN, REQ0_MODE, REQ0_CMD,
        output REQ1_VALID, REQ1_OPA, REQ1_OPB, REQ1_CIN, REQ1_MODE, REQ1_CMD,
        input  REQ0_READY, REQ1_READY,
        input  ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CIN, ALU_MODE, ALU_CMD,
        output ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR,
        output RSP_READY,
        input  RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS
    );

    modport slave (
        input  REQ0_VALID, REQ0_OPA, REQ0_OPB, REQ0_CIN, REQ0_MODE, REQ0_CMD,
        input  REQ1_VALID, REQ1_OPA, REQ1_OPB, REQ1_CIN, REQ1_MODE, REQ1_CMD,
        output REQ0_READY, REQ1_READY,
        output ALU_CE, ALU_INP_VALID, ALU_OPA, ALU_OPB, ALU_CIN, ALU_MODE, ALU_CMD,
        input  ALU_RES, ALU_COUT, ALU_OFLOW, ALU_G, ALU_E, ALU_L, ALU_ERR,
        input  RSP_READY,
        output RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Two-requester arbiter/sequencer issuing one op at a time to a multi-cycle ALU.
// Define ALU_ARB_PRIO_EN for fixed priority (REQ0 wins ties) instead of round-robin.
module alu_issue_arbiter #(
    parameter int DW      = 8,
    parameter int CW      = 4,
    parameter int LAT_STD = 2,
    parameter int LAT_MUL = 3
) (
    input logic CLK,
    input logic RST_N,
    alu_issue_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int LAT_MAX = (LAT_MUL > LAT_STD) ? LAT_MUL : LAT_STD;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic          gnt0, gnt1;
    logic [DW-1:0] op_a, op_b;
    logic          op_cin, op_mode, op_id;
    logic [CW-1:0] op_cmd;
    logic [DW+1:0] rsp_res;
    logic [5:0]    rsp_flags;

    // ALU flags may float; anything other than a solid 1 is taken as 0.
    function automatic logic flag_bit(input logic f);
        return (f === 1'b1);
    endfunction

    function automatic logic is_mul(input logic mode, input logic [CW-1:0] cmd);
        return mode && ((cmd == CW'(9)) || (cmd == CW'(10)));
    endfunction

`ifdef ALU_ARB_PRIO_EN
    always_comb begin
        gnt0 = bus.REQ0_VALID;
        gnt1 = bus.REQ1_VALID && !bus.REQ0_VALID;
    end
`else
    logic rr_last;  // 1 when REQ1 was served last, so REQ0 wins the next tie

    always_comb begin
        gnt0 = bus.REQ0_VALID && (!bus.REQ1_VALID || rr_last);
        gnt1 = bus.REQ1_VALID && (!bus.REQ0_VALID || !rr_last);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)
            rr_last <= 1'b1;
        else if ((state == IDLE) && (gnt0 || gnt1))
            rr_last <= gnt1;
    end
`endif

    always_comb begin
        state_nxt         = state;
        bus.REQ0_READY    = 1'b0;
        bus.REQ1_READY    = 1'b0;
        bus.ALU_CE        = 1'b0;
        bus.ALU_INP_VALID = 2'b00;
        bus.RSP_VALID     = 1'b0;
        case (state)
            IDLE: begin
                bus.REQ0_READY = gnt0;
                bus.REQ1_READY = gnt1;
                if (gnt0 || gnt1) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.ALU_CE        = 1'b1;
                bus.ALU_INP_VALID = 2'b11;
                state_nxt         = WAIT;
            end
            WAIT: begin
                bus.ALU_CE = 1'b1;
                if (cnt == CNT_W'(1)) state_nxt = RESP;
            end
            RESP: begin
                bus.RSP_VALID = 1'b1;
                if (bus.RSP_READY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_cin    <= 1'b0;
            op_mode   <= 1'b0;
            op_cmd    <= '0;
            op_id     <= 1'b0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (gnt0 || gnt1) begin
                    op_id   <= gnt1;
                    op_a    <= gnt1 ? bus.REQ1_OPA  : bus.REQ0_OPA;
                    op_b    <= gnt1 ? bus.REQ1_OPB  : bus.REQ0_OPB;
                    op_cin  <= gnt1 ? bus.REQ1_CIN  : bus.REQ0_CIN;
                    op_mode <= gnt1 ? bus.REQ1_MODE : bus.REQ0_MODE;
                    op_cmd  <= gnt1 ? bus.REQ1_CMD  : bus.REQ0_CMD;
                end
                ISSUE: cnt <= is_mul(op_mode, op_cmd) ? CNT_W'(LAT_MUL) : CNT_W'(LAT_STD);
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        rsp_res   <= bus.ALU_RES;
                        rsp_flags <= {flag_bit(bus.ALU_COUT), flag_bit(bus.ALU_OFLOW),
                                      flag_bit(bus.ALU_G), flag_bit(bus.ALU_E),
                                      flag_bit(bus.ALU_L), flag_bit(bus.ALU_ERR)};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ALU_OPA   = op_a;
    assign bus.ALU_OPB   = op_b;
    assign bus.ALU_CIN   = op_cin;
    assign bus.ALU_MODE  = op_mode;
    assign bus.ALU_CMD   = op_cmd;
    assign bus.RSP_ID    = op_id;
    assign bus.RSP_RES   = rsp_res;
    assign bus.RSP_FLAGS = rsp_flags;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: behavioural ALU with per-command latency,
// transaction-level reference for arbitration order, results and handshake timing.
module tb_alu_issue_arbiter;
    localparam int DW = 8;
    localparam int CW = 4;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic last_srv = 1'b1;

    logic [7:0] q_a [2];
    logic [7:0] q_b [2];
    logic       q_cin [2];
    logic       q_mode [2];
    logic [3:0] q_cmd [2];
    logic       q_vld [2];

    alu_issue_arbiter_if #(.DW(DW), .CW(CW)) bus ();
    alu_issue_arbiter #(.DW(DW), .CW(CW), .LAT_STD(2), .LAT_MUL(3)) dut (
        .CLK(CLK), .RST_N(RST_N), .bus(bus));

    always #5 CLK = ~CLK;

    function automatic int ref_lat(input logic mode, input logic [3:0] cmd);
        return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 2;
    endfunction

    function automatic logic [9:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic cin, input logic mode, input logic [3:0] cmd);
        logic [7:0] sa;
        sa = a << 1;
        if (mode) begin
            case (cmd)
                4'd0:    return {2'b00, a} + {2'b00, b};
                4'd1:    return {2'b00, a} - {2'b00, b};
                4'd2:    return {2'b00, a} + {2'b00, b} + {9'd0, cin};
                4'd9:    return ({2'b00, a} + 10'd1) * ({2'b00, b} + 10'd1);
                4'd10:   return {2'b00, sa} * {2'b00, b};
                default: return 10'd0;
            endcase
        end
        case (cmd)
            4'd0:    return {2'b00, a & b};
            4'd1:    return {2'b00, ~(a & b)};
            4'd2:    return {2'b00, a | b};
            4'd3:    return {2'b00, ~(a | b)};
            4'd4:    return {2'b00, a ^ b};
            4'd5:    return {2'b00, ~(a ^ b)};
            default: return 10'd0;
        endcase
    endfunction

    // {COUT,OFLOW,G,E,L,ERR}; flags the ALU leaves floating are represented as 0
    function automatic logic [5:0] ref_flags(input logic [7:0] a, input logic [7:0] b,
                                             input logic cin, input logic mode, input logic [3:0] cmd);
        logic [5:0] f;
        logic [9:0] s;
        f = 6'b000000;
        s = ref_res(a, b, cin, mode, cmd);
        if (mode) begin
            case (cmd)
                4'd0, 4'd2: f[5] = s[8];
                4'd1:       f[4] = (a < b);
                4'd8:       begin f[3] = (a > b); f[2] = (a == b); f[1] = (a < b); end
                4'd9, 4'd10: f = 6'b000000;
                default:    f[0] = 1'b1;
            endcase
        end else if (cmd > 4'd5) begin
            f[0] = 1'b1;
        end
        return f;
    endfunction

    // Behavioural ALU: result is only meaningful once the command latency has elapsed.
    logic [7:0] m_a = '0, m_b = '0;
    logic       m_cin = 1'b0, m_mode = 1'b0, m_live = 1'b0, m_ok;
    logic [3:0] m_cmd = '0;
    int         m_age = 0;
    logic [5:0] m_flg;

    always @(posedge CLK) begin
        if (bus.ALU_CE === 1'b1) begin
            if (bus.ALU_INP_VALID === 2'b11) begin
                m_a <= bus.ALU_OPA; m_b <= bus.ALU_OPB; m_cin <= bus.ALU_CIN;
                m_mode <= bus.ALU_MODE; m_cmd <= bus.ALU_CMD; m_age <= 0; m_live <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    assign m_ok = m_live && (m_age >= ref_lat(m_mode, m_cmd) - 1);
    assign bus.ALU_RES = m_ok ? ref_res(m_a, m_b, m_cin, m_mode, m_cmd)
                              : ~ref_res(m_a, m_b, m_cin, m_mode, m_cmd);
    assign m_flg = m_ok ? ref_flags(m_a, m_b, m_cin, m_mode, m_cmd) : 6'b111111;
    assign {bus.ALU_COUT, bus.ALU_OFLOW, bus.ALU_G, bus.ALU_E, bus.ALU_L, bus.ALU_ERR} = m_flg;

    logic [5:0]  ctl;
    logic [21:0] ops;
    logic [44:0] all_out;
    assign ctl = {bus.ALU_CE, bus.ALU_INP_VALID, bus.RSP_VALID, bus.REQ1_READY, bus.REQ0_READY};
    assign ops = {bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CIN, bus.ALU_MODE, bus.ALU_CMD};
    assign all_out = {bus.REQ0_READY, bus.REQ1_READY, bus.ALU_CE, bus.ALU_INP_VALID, ops,
                      bus.RSP_VALID, bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS};

    task automatic apply_reqs();
        bus.REQ0_VALID = q_vld[0]; bus.REQ0_OPA = q_a[0]; bus.REQ0_OPB = q_b[0];
        bus.REQ0_CIN = q_cin[0]; bus.REQ0_MODE = q_mode[0]; bus.REQ0_CMD = q_cmd[0];
        bus.REQ1_VALID = q_vld[1]; bus.REQ1_OPA = q_a[1]; bus.REQ1_OPB = q_b[1];
        bus.REQ1_CIN = q_cin[1]; bus.REQ1_MODE = q_mode[1]; bus.REQ1_CMD = q_cmd[1];
    endtask

    task automatic clear_reqs();
        for (int n = 0; n < 2; n++) begin
            q_vld[n] = 1'b0; q_a[n] = '0; q_b[n] = '0;
            q_cin[n] = 1'b0; q_mode[n] = 1'b0; q_cmd[n] = '0;
        end
        apply_reqs();
    endtask

    task automatic set_op(input int n, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic mode, input logic [3:0] cmd);
        q_vld[n] = 1'b1; q_a[n] = a; q_b[n] = b; q_cin[n] = cin; q_mode[n] = mode; q_cmd[n] = cmd;
    endtask

    task automatic rand_op(input int n);
        int sel;
        set_op(n, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 4'd0);
        sel = int'($urandom_range(0, 5));
        if (q_mode[n]) begin
            case (sel)
                0: q_cmd[n] = 4'd0;
                1: q_cmd[n] = 4'd1;
                2: q_cmd[n] = 4'd2;
                3: q_cmd[n] = 4'd8;
                4: q_cmd[n] = 4'd9;
                default: q_cmd[n] = 4'd10;
            endcase
        end else begin
            q_cmd[n] = 4'(sel);
        end
    endtask

    // Starts and ends just after a falling edge with the arbiter idle.
    task automatic run_txn(input int rsp_delay, output int o_id,
                           output logic [9:0] o_res, output logic [5:0] o_flg);
        int win, lat;
        logic [7:0] a, b;
        logic cin, mode;
        logic [3:0] cmd;
        logic [9:0] eres;
        logic [5:0] eflg;
        apply_reqs();
        #1;
        if (q_vld[0] && q_vld[1]) begin
`ifdef ALU_ARB_PRIO_EN
            win = 0;
`else
            win = last_srv ? 0 : 1;
`endif
        end else begin
            win = q_vld[0] ? 0 : 1;
        end
        checks++;
        if ({bus.REQ1_READY, bus.REQ0_READY} !== ((win == 1) ? 2'b10 : 2'b01)) begin
            failures++;
            $display("FAIL grant: ready=%b expected=%b", {bus.REQ1_READY, bus.REQ0_READY},
                     (win == 1) ? 2'b10 : 2'b01);
        end
        a = q_a[win]; b = q_b[win]; cin = q_cin[win]; mode = q_mode[win]; cmd = q_cmd[win];
        eres = ref_res(a, b, cin, mode, cmd);
        eflg = ref_flags(a, b, cin, mode, cmd);
        lat  = ref_lat(mode, cmd);
        last_srv = win[0];
        o_id = win; o_res = 'x; o_flg = 'x;
        @(posedge CLK);
        @(negedge CLK);
        q_vld[win] = 1'b0;
        apply_reqs();
        #1;
        checks++;
        if (ctl !== 6'b1_11_0_00) begin
            failures++; $display("FAIL issue_ctl: got=%b expected=%b", ctl, 6'b1_11_0_00);
        end
        checks++;
        if (ops !== {a, b, cin, mode, cmd}) begin
            failures++; $display("FAIL issue_ops: got=%h expected=%h", ops, {a, b, cin, mode, cmd});
        end
        for (int k = 0; k < lat; k++) begin
            @(negedge CLK); #1;
            checks++;
            if (ctl !== 6'b1_00_0_00 || ops !== {a, b, cin, mode, cmd}) begin
                failures++;
                $display("FAIL wait_cycle%0d: ctl=%b ops=%h expected ctl=%b ops=%h",
                         k, ctl, ops, 6'b1_00_0_00, {a, b, cin, mode, cmd});
            end
        end
        @(negedge CLK); #1;
        o_res = bus.RSP_RES; o_flg = bus.RSP_FLAGS;
        for (int d = 0; d <= rsp_delay; d++) begin
            if (d > 0) begin @(negedge CLK); #1; end
            checks++;
            if (ctl !== 6'b0_00_1_00) begin
                failures++; $display("FAIL resp_ctl%0d: got=%b expected=%b", d, ctl, 6'b0_00_1_00);
            end
            checks++;
            if ({bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS} !== {win[0], eres, eflg}) begin
                failures++;
                $display("FAIL resp_data%0d: id=%b res=%h flags=%b expected id=%b res=%h flags=%b",
                         d, bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS, win[0], eres, eflg);
            end
        end
        bus.RSP_READY = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        bus.RSP_READY = 1'b0;
        #1;
        checks++;
        if (bus.RSP_VALID !== 1'b0) begin
            failures++; $display("FAIL resp_drop: rsp_valid=%b expected=0", bus.RSP_VALID);
        end
    endtask

    task automatic test_reset();
        clear_reqs();
        bus.RSP_READY = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL reset_outputs: got=%h expected=0", all_out);
        end
        RST_N = 1'b1;
        last_srv = 1'b1;
        repeat (3) begin
            @(negedge CLK); #1;
            checks++;
            if (all_out !== '0) begin
                failures++; $display("FAIL idle_outputs: got=%h expected=0", all_out);
            end
        end
    endtask

    task automatic test_basic();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        set_op(0, 8'hFF, 8'h01, 1'b0, 1'b1, 4'd0);
        run_txn(0, id, r, f);
        checks++;
        if (r !== 10'h100 || f[5] !== 1'b1 || bus.RSP_ID !== 1'b0) begin
            failures++; $display("FAIL add_ff_01: res=%h cout=%b id=%b expected res=100 cout=1 id=0",
                                 r, f[5], bus.RSP_ID);
        end
    endtask

    task automatic test_mul();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        set_op(0, 8'd3, 8'd4, 1'b0, 1'b1, 4'd9);
        run_txn(0, id, r, f);
        checks++;
        if (r !== 10'd20 || f !== 6'b000000) begin
            failures++; $display("FAIL mul_3_4: res=%0d flags=%b expected res=20 flags=000000", r, f);
        end
    endtask

    task automatic test_cmp();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        set_op(1, 8'd5, 8'd5, 1'b0, 1'b1, 4'd8);
        run_txn(0, id, r, f);
        checks++;
        if (f !== 6'b000100) begin
            failures++; $display("FAIL cmp_eq: flags=%b expected=000100", f);
        end
    endtask

    task automatic test_back_to_back();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        rand_op(0);
        rand_op(1);
        for (int i = 0; i < 4; i++) begin
            run_txn(0, id, r, f);
            rand_op(id);
        end
    endtask

    task automatic test_stall();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        rand_op(0);
        rand_op(1);
        run_txn(10, id, r, f);
    endtask

    task automatic test_reset_mid();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        set_op(0, 8'd7, 8'd9, 1'b0, 1'b1, 4'd9);
        apply_reqs();
        @(posedge CLK);
        @(negedge CLK);
        q_vld[0] = 1'b0;
        apply_reqs();
        @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK);
        @(negedge CLK); #1;
        checks++;
        if (all_out !== '0) begin
            failures++; $display("FAIL midop_reset: got=%h expected=0", all_out);
        end
        RST_N = 1'b1;
        last_srv = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK); #1;
            checks++;
            if (all_out !== '0) begin
                failures++; $display("FAIL dropped_op%0d: got=%h expected=0", k, all_out);
            end
        end
        rand_op(0);
        rand_op(1);
        run_txn(1, id, r, f);
        run_txn(0, id, r, f);
    endtask

    task automatic test_random();
        int id; logic [9:0] r; logic [5:0] f;
        clear_reqs();
        for (int i = 0; i < 40; i++) begin
            for (int n = 0; n < 2; n++)
                if (!q_vld[n] && $urandom_range(0, 1) == 1) rand_op(n);
            if (!q_vld[0] && !q_vld[1]) rand_op(int'($urandom_range(0, 1)));
            run_txn(int'($urandom_range(0, 3)), id, r, f);
        end
    endtask

    initial begin
        bus.RSP_READY = 1'b0;
        clear_reqs();
        test_reset();
        test_basic();
        test_mul();
        test_cmp();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
